// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo block.
// Optional occupancy output is enabled by defining SYNC_FIFO_OCCUPANCY_EN.
package sync_fifo_pkg;

  localparam int FIFO_WIDTH_DEF     = 8;
  localparam int FIFO_DEPTH_DEF     = 16;
  localparam int FIFO_PTR_WIDTH_DEF = $clog2(FIFO_DEPTH_DEF);

  // Pointer pattern: logic [PTR_WIDTH:0]. The low PTR_WIDTH bits address
  // storage and the MSB is the wrap bit that separates full from empty.
  // This typedef covers the default depth. Modules with a non-default
  // DEPTH declare their own local copy of the same shape.
  typedef logic [FIFO_PTR_WIDTH_DEF:0] ptr_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// The count signal exists only when SYNC_FIFO_OCCUPANCY_EN is defined.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) ();

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             wr_en;
  logic             rd_en;
  logic             empty;
  logic             full;
  logic             wr_error;
  logic             rd_error;
`ifdef SYNC_FIFO_OCCUPANCY_EN
  logic [PTR_WIDTH:0] count;
`endif

  // Producer/consumer side.
  modport master (
    output wdata, wr_en, rd_en,
    input  rdata, empty, full, wr_error, rd_error
`ifdef SYNC_FIFO_OCCUPANCY_EN
    , input count
`endif
  );

  // FIFO side.
  modport slave (
    input  wdata, wr_en, rd_en,
    output rdata, empty, full, wr_error, rd_error
`ifdef SYNC_FIFO_OCCUPANCY_EN
    , output count
`endif
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// The array is not reset. Only the read data register clears on reset,
// so rdata starts at zero.
module sync_fifo_mem #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [PTR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [PTR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage write. There is no reset so this can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read. The value holds until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, full/empty flags and overflow/underflow
// error pulses. Storage lives in sync_fifo_mem.
// Define SYNC_FIFO_OCCUPANCY_EN to add the combinational count output.
// DEPTH must be a power of two and at least 2.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  sync_fifo_if.slave  bus
);

  typedef logic [PTR_WIDTH:0] fifo_ptr_t;
  localparam fifo_ptr_t PTR_ONE = fifo_ptr_t'(1);

  fifo_ptr_t wr_ptr_q, wr_ptr_d;
  fifo_ptr_t rd_ptr_q, rd_ptr_d;
  logic      wr_error_q, wr_error_d;
  logic      rd_error_q, rd_error_d;
  logic      empty, full;
  logic      wr_accept, rd_accept;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                 (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

  // A request is judged only against the flags at this edge, so a
  // simultaneous read cannot make room for a write in the same cycle.
  assign wr_accept = bus.wr_en & ~full;
  assign rd_accept = bus.rd_en & ~empty;

  // Next-state logic for the pointers and error pulses.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_error_d = bus.wr_en & full;
    rd_error_d = bus.rd_en & empty;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // State registers. Asserting reset clears them at once, mid-stream included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_error_q <= wr_error_d;
      rd_error_q <= rd_error_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr_accept),
    .waddr (wr_ptr_q[PTR_WIDTH-1:0]),
    .wdata (bus.wdata),
    .re    (rd_accept),
    .raddr (rd_ptr_q[PTR_WIDTH-1:0]),
    .rdata (bus.rdata)
  );

  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.wr_error = wr_error_q;
  assign bus.rd_error = rd_error_q;

`ifdef SYNC_FIFO_OCCUPANCY_EN
  // The wrap bit makes the modular difference cover 0..DEPTH.
  assign bus.count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed testbench for sync_fifo. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  sync_fifo_if #(.WIDTH(FIFO_WIDTH_DEF), .DEPTH(FIFO_DEPTH_DEF)) bus ();

  sync_fifo #(.WIDTH(FIFO_WIDTH_DEF), .DEPTH(FIFO_DEPTH_DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wdata = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk(tag, 32'(bus.rdata), 32'(exp));
  endtask

  task automatic chk_count(input string tag, input int exp);
`ifdef SYNC_FIFO_OCCUPANCY_EN
    chk(tag, 32'(bus.count), 32'(exp));
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wdata = '0;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_wr_err", 32'(bus.wr_error), 0);
    chk("rst_rd_err", 32'(bus.rd_error), 0);
    chk_count("rst_count", 0);
    reset = 1'b1;
    tick();
    chk("idle_empty", 32'(bus.empty), 1);
    chk("idle_full", 32'(bus.full), 0);

    // Fill with 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      if (i == 14) chk("fill15_full", 32'(bus.full), 0);
    end
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_empty", 32'(bus.empty), 0);
    chk("fill_wr_err", 32'(bus.wr_error), 0);
    chk_count("fill_count", 16);
    wr(8'hAA);
    chk("ovf_wr_err", 32'(bus.wr_error), 1);
    chk("ovf_full", 32'(bus.full), 1);
    tick();
    chk("ovf_pulse_end", 32'(bus.wr_error), 0);

    // Drain. 0x00 coming back first shows the rejected 0xAA was not stored.
    for (int i = 0; i < 16; i++) begin
      rd_chk($sformatf("drain%0d", i), 8'(i));
      if (i == 0) chk("drain_rd_err", 32'(bus.rd_error), 0);
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_full", 32'(bus.full), 0);
    rd_chk("udf_rdata_hold", 8'h0F);
    chk("udf_rd_err", 32'(bus.rd_error), 1);
    tick();
    chk("udf_pulse_end", 32'(bus.rd_error), 0);

    // Wrap: 10 in, 10 out, then a full 16 across the pointer wrap.
    for (int i = 0; i < 10; i++) wr(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) rd_chk($sformatf("wrap_a%0d", i), 8'h10 + 8'(i));
    chk("wrap_a_empty", 32'(bus.empty), 1);
    for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
    chk("wrap_full", 32'(bus.full), 1);
    chk_count("wrap_count", 16);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("wrap_b%0d", i), 8'h20 + 8'(i));
    chk("wrap_empty", 32'(bus.empty), 1);
    chk("wrap_not_full", 32'(bus.full), 0);

    // Simultaneous read and write with 5 entries held.
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.wdata = 8'h35 + 8'(i);
      tick();
      chk($sformatf("sim_rdata%0d", i), 32'(bus.rdata), 32'(8'h30 + 8'(i)));
      chk($sformatf("sim_errs%0d", i), {30'b0, bus.wr_error, bus.rd_error}, 0);
      chk_count($sformatf("sim_count%0d", i), 5);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("sim_empty", 32'(bus.empty), 0);
    chk("sim_full", 32'(bus.full), 0);
    for (int i = 0; i < 5; i++) rd_chk($sformatf("sim_drain%0d", i), 8'h34 + 8'(i));
    chk("sim_drain_empty", 32'(bus.empty), 1);

    // Simultaneous read and write while full.
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
    chk("fsim_full_pre", 32'(bus.full), 1);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.wdata = 8'h99;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("fsim_rdata", 32'(bus.rdata), 32'h40);
    chk("fsim_wr_err", 32'(bus.wr_error), 1);
    chk("fsim_rd_err", 32'(bus.rd_error), 0);
    chk("fsim_full", 32'(bus.full), 0);
    chk_count("fsim_count", 15);
    for (int i = 1; i < 16; i++) rd_chk($sformatf("fsim_drain%0d", i), 8'h40 + 8'(i));
    chk("fsim_empty", 32'(bus.empty), 1);

    // Async reset with 8 entries held, applied between clock edges.
    for (int i = 0; i < 8; i++) wr(8'h50 + 8'(i));
    chk("ar_pre_empty", 32'(bus.empty), 0);
    chk_count("ar_pre_count", 8);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_empty", 32'(bus.empty), 1);
    chk("ar_full", 32'(bus.full), 0);
    chk("ar_rdata", 32'(bus.rdata), 0);
    chk_count("ar_count", 0);
    reset = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("ar_rd_err", 32'(bus.rd_error), 1);
    chk("ar_post_empty", 32'(bus.empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
